// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared state encoding and constants for the MAC convolution sequencer
package mac_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLR,
      ST_FETCH,
      ST_DRAIN,
      ST_DONE
   } state_t;

   localparam int DRAIN_CYCLES = 3;
   localparam int SRAM_RD_LAT  = 1;

   localparam logic [1:0] NORM_PASS = 2'd0;
   localparam logic [1:0] NORM_SHR4 = 2'd1;
   localparam logic [1:0] NORM_SHR8 = 2'd2;
   localparam logic [1:0] NORM_SAT8 = 2'd3;

   // Counter width able to hold values 0..n-1, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mac_win_cnt.sv
// rtl/mac_win_cnt.sv - nested kx/ky tap counter and col/row window counter with wrap flags
module mac_win_cnt
   import mac_pkg::*;
#(
   parameter int K     = 3,
   parameter int OUT_W = 26,
   parameter int OUT_H = 26,
   localparam int KW   = cnt_w(K),
   localparam int CW   = cnt_w(OUT_W),
   localparam int RW   = cnt_w(OUT_H + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          tap_clr,
   input  logic          tap_inc,
   input  logic          win_clr,
   input  logic          win_inc,
   output logic [KW-1:0] kx,
   output logic [KW-1:0] ky,
   output logic [CW-1:0] col,
   output logic [RW-1:0] row,
   output logic          tap_last,
   output logic          win_last
);

   logic kx_wrap;
   logic col_wrap;

   assign kx_wrap  = (kx == KW'(K - 1));
   assign tap_last = kx_wrap && (ky == KW'(K - 1));
   assign col_wrap = (col == CW'(OUT_W - 1));
   assign win_last = col_wrap && (row == RW'(OUT_H - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         kx <= '0;
         ky <= '0;
      end else if (tap_clr || (tap_inc && tap_last)) begin
         kx <= '0;
         ky <= '0;
      end else if (tap_inc) begin
         if (kx_wrap) begin
            kx <= '0;
            ky <= ky + 1'b1;
         end else begin
            kx <= kx + 1'b1;
         end
      end
   end

   // row is allowed to step one past the last output row; the FSM leaves on win_last.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col <= '0;
         row <= '0;
      end else if (win_clr) begin
         col <= '0;
         row <= '0;
      end else if (win_inc) begin
         if (col_wrap) begin
            col <= '0;
            row <= row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

endmodule

// File: rtl/mac_conv_ctrl.sv
// rtl/mac_conv_ctrl.sv - KxK valid-mode convolution sequencer for one MAC; MAC_CTRL_PERF_EN adds perf_cycles
module mac_conv_ctrl
   import mac_pkg::*;
#(
   parameter int IMG_W   = 28,
   parameter int IMG_H   = 28,
   parameter int K       = 3,
   parameter int PADDR_W = 10,
   parameter int WADDR_W = 4,
   parameter int OADDR_W = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [1:0]         norm_mode,
   output logic               busy,
   output logic               done,
   output logic [PADDR_W-1:0] pic_addr,
   output logic [WADDR_W-1:0] wgt_addr,
   output logic               mac_acc_en,
   output logic               mac_clr,
   output logic [1:0]         mac_norm_mode,
   output logic               result_valid,
   output logic [OADDR_W-1:0] result_addr
`ifdef MAC_CTRL_PERF_EN
   ,
   output logic [15:0]        perf_cycles
`endif
);

   localparam int OUT_W = IMG_W - K + 1;
   localparam int OUT_H = IMG_H - K + 1;
   localparam int KW    = cnt_w(K);
   localparam int CW    = cnt_w(OUT_W);
   localparam int RW    = cnt_w(OUT_H + 1);

   state_t        state;
   state_t        state_nxt;
   logic [1:0]    drain_cnt;
   logic          drain_last;
   logic          acc_en_q;
   logic [1:0]    mode_q;
   logic          accept;
   logic [KW-1:0] kx;
   logic [KW-1:0] ky;
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic          tap_last;
   logic          win_last;

   assign accept        = (state == ST_IDLE) && start;
   assign drain_last    = (drain_cnt == 2'(DRAIN_CYCLES - 1));
   assign mac_acc_en    = acc_en_q;
   assign mac_norm_mode = mode_q;

   mac_win_cnt #(
      .K     (K),
      .OUT_W (OUT_W),
      .OUT_H (OUT_H)
   ) u_win_cnt (
      .clk      (clk),
      .rst      (rst),
      .tap_clr  (state == ST_CLR),
      .tap_inc  (state == ST_FETCH),
      .win_clr  (accept),
      .win_inc  (result_valid),
      .kx       (kx),
      .ky       (ky),
      .col      (col),
      .row      (row),
      .tap_last (tap_last),
      .win_last (win_last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         drain_cnt <= '0;
         acc_en_q  <= 1'b0;
         mode_q    <= '0;
      end else begin
         state     <= state_nxt;
         // SRAM data lags its address by one cycle, so accumulate one cycle behind fetch.
         acc_en_q  <= (state == ST_FETCH);
         drain_cnt <= ((state == ST_DRAIN) && !drain_last) ? drain_cnt + 2'd1 : 2'd0;
         if (accept) begin
            mode_q <= norm_mode;
         end
      end
   end

   always_comb begin
      state_nxt    = state;
      busy         = (state != ST_IDLE);
      done         = 1'b0;
      mac_clr      = 1'b0;
      result_valid = 1'b0;
      pic_addr     = '0;
      wgt_addr     = '0;
      result_addr  = '0;
      case (state)
         ST_IDLE: begin
            if (start) state_nxt = ST_CLR;
         end
         ST_CLR: begin
            mac_clr   = 1'b1;
            state_nxt = ST_FETCH;
         end
         ST_FETCH: begin
            pic_addr = PADDR_W'((32'(row) + 32'(ky)) * IMG_W + 32'(col) + 32'(kx));
            wgt_addr = WADDR_W'(32'(ky) * K + 32'(kx));
            if (tap_last) state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (drain_last) begin
               result_valid = 1'b1;
               result_addr  = OADDR_W'(32'(row) * OUT_W + 32'(col));
               state_nxt    = win_last ? ST_DONE : ST_CLR;
            end
         end
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

`ifdef MAC_CTRL_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_cycles <= '0;
      end else if (accept) begin
         perf_cycles <= '0;
      end else if (busy && (perf_cycles != 16'hFFFF)) begin
         perf_cycles <= perf_cycles + 16'd1;
      end
   end
`endif

endmodule
